imem_fetch_ctrl: RTL and testbench

Fetch controller for the single-cycle datapath's word-addressed instruction memory. After reset it streams a program into the memory through a write port, then waits for `start`. It then sequences the PC, presenting one instruction per accepted fetch to decode, and applies branch and jump redirects (bleu, jal). It halts when the PC runs past the loaded program.

---
 rtl/imem_fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: loads a program into a word-addressed instruction memory,
// waits for start, then fetches one instruction per accepted cycle with
// branch/jump redirects, halting once the PC runs past the loaded program.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   load_valid/ready/data/last      program loader handshake
//   start                           begin or restart execution
//   imem_we/wa/wd                   instruction memory write port
//   imem_a/imem_rd                  instruction memory read port (comb read)
//   instr/instr_valid/instr_ready   fetched instruction to decode
//   redirect/redirect_pc            taken branch or jump target
//   pc/pc_plus4                     address of instr and its link value
//   halted                          controller is in HALT
module imem_fetch_ctrl #(
    parameter int unsigned DEPTH    = 20,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        start,
    output logic        imem_we,
    output logic [31:0] imem_wa,
    output logic [31:0] imem_wd,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_WAIT_START,
        S_RUN,
        S_HALT
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    pc_q, pc_d;

    logic           load_hs;
    logic           in_range;
    logic           run;
    logic [31:0]    limit;
    logic           unused_rpc_lsb;

    // Targets are forced word-aligned, so the low address bits carry no information.
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // Output decode from the state/count/pc registers.
    assign run         = (state_q == S_RUN);
    assign load_ready  = (state_q == S_LOAD);
    assign halted      = (state_q == S_HALT);
    assign load_hs     = load_valid & load_ready;
    assign limit       = 32'(count_q) << 2;
    assign in_range    = (pc_q < limit);

    assign imem_we     = load_hs;
    assign imem_wa     = limit;
    assign imem_wd     = load_data;
    assign imem_a      = pc_q;
    assign instr       = run ? imem_rd : 32'h0;
    // A redirect squashes the word currently presented.
    assign instr_valid = run & in_range & ~redirect;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pc_d    = pc_q;
        case (state_q)
            S_LOAD: begin
                if (load_hs) begin
                    count_d = count_q + CW'(1);
                    if (load_last || (count_d == CW'(DEPTH))) begin
                        state_d = S_WAIT_START;
                    end
                end
            end
            S_WAIT_START, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
            end
            S_RUN: begin
                if (redirect) begin
                    pc_d = {redirect_pc[31:2], 2'b00};
                end else if (!in_range) begin
                    state_d = S_HALT;
                end else if (instr_ready) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_LOAD;
            count_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with a behavioural instruction memory.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        start;
    logic        imem_we;
    logic [31:0] imem_wa;
    logic [31:0] imem_wd;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:31];
    logic [31:0] prog [0:8];
    logic [63:0] exp_q [$];

    imem_fetch_ctrl #(.DEPTH(20), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .start(start),
        .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
        .imem_a(imem_a), .imem_rd(imem_rd),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (imem_we) mem[imem_wa[6:2]] <= imem_wd;
    assign imem_rd = mem[imem_a[6:2]];

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        sample();
        vectors++;
        if ({load_ready, imem_we, instr_valid, halted} !== 4'b1000 || instr !== 32'h0 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: ready/we/valid/halted=%b instr=%h pc=%h, want 1000 0 0",
                     {load_ready, imem_we, instr_valid, halted}, instr, pc);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 8);
            sample();
            vectors++;
            if (imem_we !== 1'b1 || imem_wa !== 32'(i * 4) || imem_wd !== prog[i]) begin
                miscompares++;
                $display("FAIL load_write[%0d]: we=%b wa=%h wd=%h, want 1 %h %h",
                         i, imem_we, imem_wa, imem_wd, 32'(i * 4), prog[i]);
            end
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        sample();
        vectors++;
        if ({load_ready, instr_valid, halted} !== 3'b000) begin
            miscompares++;
            $display("FAIL load_done: ready/valid/halted=%b, want 000",
                     {load_ready, instr_valid, halted});
        end
        tick();
    endtask

    task automatic test_run_stream();
        int used;
        logic [63:0] e;
        for (int i = 0; i < 9; i++) exp_q.push_back({32'(i * 4), prog[i]});
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        used = 0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            sample();
            used++;
            if (instr_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if ({pc, instr} !== e || pc_plus4 !== e[63:32] + 32'd4) begin
                    miscompares++;
                    $display("FAIL stream: pc=%h instr=%h pc4=%h, want %h %h %h",
                             pc, instr, pc_plus4, e[63:32], e[31:0], e[63:32] + 32'd4);
                end
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0 || used != 9) begin
            miscompares++;
            $display("FAIL stream_throughput: cycles=%0d left=%0d, want 9 0", used, exp_q.size());
            exp_q.delete();
        end
        sample();
        vectors++;
        if (pc !== 32'h24 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end: pc=%h valid=%b halted=%b, want 24 0 0", pc, instr_valid, halted);
        end
        tick();
        sample();
        vectors++;
        if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_halt: halted=%b valid=%b, want 1 0", halted, instr_valid);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [63:0] e;
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        sample();
        vectors++;
        if (pc !== 32'h0 || instr_valid !== 1'b1 || instr !== prog[0]) begin
            miscompares++;
            $display("FAIL restart: pc=%h valid=%b instr=%h, want 0 1 %h", pc, instr_valid, instr, prog[0]);
        end
        tick();
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({32'h8, 32'h8020_2000});
            sample();
            e = exp_q.pop_front();
            vectors++;
            if (instr_valid !== 1'b1 || {pc, instr} !== e) begin
                miscompares++;
                $display("FAIL stall[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                         i, instr_valid, pc, instr, e[63:32], e[31:0]);
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        sample();
        vectors++;
        if (pc !== 32'hC || instr_valid !== 1'b1 || instr !== prog[3]) begin
            miscompares++;
            $display("FAIL stall_release: pc=%h valid=%b instr=%h, want c 1 %h", pc, instr_valid, instr, prog[3]);
        end
    endtask

    task automatic test_redirect();
        int n;
        redirect = 1'b1;
        redirect_pc = 32'h19;
        #1;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_squash: valid=%b, want 0", instr_valid);
        end
        tick();
        redirect = 1'b0;
        sample();
        vectors++;
        if (pc !== 32'h18 || instr !== prog[6] || pc_plus4 !== 32'h1C || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL redirect_target: pc=%h instr=%h pc4=%h valid=%b, want 18 %h 1c 1",
                     pc, instr, pc_plus4, instr_valid, prog[6]);
        end
        n = 0;
        while (!halted && n < 10) begin
            tick();
            sample();
            n++;
        end
        vectors++;
        if (halted !== 1'b1 || n != 4) begin
            miscompares++;
            $display("FAIL redirect_halt: halted=%b cycles=%0d, want 1 4", halted, n);
        end
        tick();
    endtask

    task automatic test_halt_ignores_redirect();
        redirect = 1'b1;
        redirect_pc = 32'h4;
        tick();
        redirect = 1'b0;
        sample();
        vectors++;
        if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_redirect: halted=%b valid=%b, want 1 0", halted, instr_valid);
        end
        tick();
    endtask

    task automatic test_redirect_oob();
        start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        sample();
        vectors++;
        if (pc !== 32'h40 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_target: pc=%h valid=%b halted=%b, want 40 0 0", pc, instr_valid, halted);
        end
        tick();
        sample();
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_halt: halted=%b, want 1", halted);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        sample();
        vectors++;
        if (pc !== 32'h10 || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: pc=%h valid=%b, want 10 1", pc, instr_valid);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sample();
        vectors++;
        if ({load_ready, instr_valid, halted} !== 3'b100 || pc !== 32'h0 || instr !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: ready/valid/halted=%b pc=%h instr=%h, want 100 0 0",
                     {load_ready, instr_valid, halted}, pc, instr);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        vectors++;
        if (load_ready !== 1'b1 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_ignores_start: ready=%b valid=%b, want 1 0", load_ready, instr_valid);
        end
        tick();
    endtask

    task automatic test_full_depth();
        logic [63:0] e;
        int used;
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = 32'hA000_0000 | 32'(i);
            exp_q.push_back({32'(i * 4), 32'hA000_0000 | 32'(i)});
            sample();
            vectors++;
            if (imem_we !== 1'b1 || imem_wa !== 32'(i * 4) || load_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL depth_write[%0d]: we=%b wa=%h ready=%b, want 1 %h 1",
                         i, imem_we, imem_wa, load_ready, 32'(i * 4));
            end
            tick();
        end
        load_data = 32'hDEAD_BEEF;
        sample();
        vectors++;
        if (load_ready !== 1'b0 || imem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL depth_full: ready=%b we=%b, want 0 0", load_ready, imem_we);
        end
        tick();
        load_valid = 1'b0;
        start = 1'b1;
        instr_ready = 1'b1;
        tick();
        start = 1'b0;
        used = 0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            sample();
            used++;
            if (instr_valid) begin
                e = exp_q.pop_front();
                vectors++;
                if ({pc, instr} !== e) begin
                    miscompares++;
                    $display("FAIL depth_run: pc=%h instr=%h, want %h %h", pc, instr, e[63:32], e[31:0]);
                end
            end
            tick();
        end
        sample();
        vectors++;
        if (exp_q.size() != 0 || used != 20 || pc !== 32'h50 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL depth_end: cycles=%0d left=%0d pc=%h valid=%b, want 20 0 50 0",
                     used, exp_q.size(), pc, instr_valid);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        prog[0] = 32'h8C01_0000;  // lw
        prog[1] = 32'h8C02_0004;  // lw
        prog[2] = 32'h8020_2000;  // add
        prog[3] = 32'h1862_0010;  // bleu
        prog[4] = 32'h2043_1800;  // nora
        prog[5] = 32'h3064_2000;  // rolv
        prog[6] = 32'h3465_2800;  // rorv
        prog[7] = 32'h0C00_0004;  // jal
        prog[8] = 32'h3066_3000;  // rolv
        reset_n = 1'b0;
        load_valid = 1'b0;
        load_data = 32'h0;
        load_last = 1'b0;
        start = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        tick();
        test_reset();
        test_load();
        test_run_stream();
        test_stall();
        test_redirect();
        test_halt_ignores_redirect();
        test_redirect_oob();
        test_reset_mid_run();
        test_full_depth();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
